// File: rtl/lsu_bus_master_pkg.sv
// Shared encodings for the MEM-stage load/store bus master: access sizes,
// FSM states and the word-address helper.
package lsu_bus_master_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replicated write data, load
// lane extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import lsu_bus_master_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every output takes a default before the case so no path can infer a latch.
        be         = BE_ALL;
        lane_wdata = wdata;
        ld_data    = rdata;
        misaligned = 1'b0;
        case (size_e'(size))
            SIZE_WORD: misaligned = (lane != 2'b00);
            SIZE_HALF: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                ld_data    = {{16{rd_half[15] & ~zero_ext}}, rd_half};
                misaligned = lane[0];
            end
            SIZE_BYTE: begin
                be         = 4'b0001 << lane;
                lane_wdata = {4{wdata[7:0]}};
                ld_data    = {{24{rd_byte[7] & ~zero_ext}}, rd_byte};
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: runs one memory op as a req/ack bus
// transaction, stalls the pipeline meanwhile, and flags misalignment/timeouts.
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_we,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [31:0] op_pc,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        err_adel,
    output logic        err_ades,
    output logic        err_bus,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    output logic [31:0] m_pc,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_e        state, state_next;
    logic [TW-1:0] timer;
    logic [1:0]    lat_lane;
    logic [1:0]    lat_size;
    logic          lat_zext;

    logic          accept, reject, ack_hit, timed_out;
    logic [1:0]    al_lane, al_size;
    logic          al_zext, al_misaligned;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata, al_ld;

    // In IDLE the aligner looks at the incoming op; afterwards at the latched one.
    assign al_lane = (state == ST_IDLE) ? op_addr[1:0] : lat_lane;
    assign al_size = (state == ST_IDLE) ? op_size      : lat_size;
    assign al_zext = (state == ST_IDLE) ? op_unsigned  : lat_zext;

    lsu_align u_align (
        .lane       (al_lane),
        .size       (al_size),
        .zero_ext   (al_zext),
        .wdata      (op_wdata),
        .rdata      (m_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .ld_data    (al_ld),
        .misaligned (al_misaligned)
    );

    assign m_req = (state == ST_WAIT);
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        ack_hit    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (al_misaligned) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                // An ack in the final timer cycle still completes normally.
                if (m_ack) begin
                    ack_hit    = 1'b1;
                    state_next = ST_DONE;
                end else if (timer == TIMER_LAST) begin
                    timed_out  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer    <= '0;
            err_adel <= 1'b0;
            err_ades <= 1'b0;
            err_bus  <= 1'b0;
            ld_data  <= '0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_be     <= '0;
            m_wdata  <= '0;
            m_pc     <= '0;
            lat_lane <= '0;
            lat_size <= '0;
            lat_zext <= 1'b0;
        end else begin
            timer    <= (state == ST_WAIT) ? timer + TW'(1) : '0;
            err_adel <= reject & ~op_we;
            err_ades <= reject & op_we;
            err_bus  <= timed_out;
            if (accept) begin
                m_we     <= op_we;
                m_addr   <= word_addr(op_addr);
                m_be     <= op_we ? al_be : BE_ALL;
                m_wdata  <= al_wdata;
                m_pc     <= op_pc;
                lat_lane <= op_addr[1:0];
                lat_size <= op_size;
                lat_zext <= op_unsigned;
            end
            if (ack_hit)                  ld_data <= m_we ? '0 : al_ld;
            else if (timed_out || reject) ld_data <= '0;
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: directed corner cases plus random ops,
// checked against a byte-level reference model of the load/store rules.
module tb_lsu_bus_master;
    import lsu_bus_master_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_we, op_unsigned;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata, op_pc;
    logic        stall, done, err_adel, err_ades, err_bus;
    logic [31:0] ld_data;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_pc, m_rdata;
    logic [3:0]  m_be;

    lsu_bus_master #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_we       (op_we),
        .op_size     (op_size),
        .op_unsigned (op_unsigned),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .op_pc       (op_pc),
        .stall       (stall),
        .done        (done),
        .ld_data     (ld_data),
        .err_adel    (err_adel),
        .err_ades    (err_ades),
        .err_bus     (err_bus),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_be        (m_be),
        .m_wdata     (m_wdata),
        .m_pc        (m_pc),
        .m_ack       (m_ack),
        .m_rdata     (m_rdata)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc++;

    // flags = {done, err_adel, err_ades, err_bus} in the cycle the op retires
    typedef struct {
        logic [3:0]  flags;
        logic [31:0] ld;
        int          due;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] pc;
    } bus_t;

    res_t res_q[$];
    bus_t bus_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 4;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
        int n   = size_bytes(size);
        int off = int'(addr & 32'h3);
        return (n == 0) || ((off % n) != 0);
    endfunction

    function automatic logic [31:0] load_value(input logic [1:0] size, input bit uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        int          n   = size_bytes(size);
        int          off = int'(addr & 32'h3);
        logic [31:0] mask, v;
        if (n == 4) return rdata;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v    = (rdata >> (8 * off)) & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bus_t bus_expect(input bit we, input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [31:0] pc);
        bus_t b;
        int   n   = size_bytes(size);
        int   off = int'(addr & 32'h3);
        b.we    = we;
        b.addr  = addr & ~32'h3;
        b.pc    = pc;
        b.be    = 4'b1111;
        b.wdata = wdata;
        if (we) begin
            b.be = 4'b0000;
            for (int i = 0; i < n; i++) b.be[off+i] = 1'b1;
            for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = wdata[8*(k%n) +: 8];
        end
        return b;
    endfunction

    // ---------------- stimulus ----------------
    // ack_wait: WAIT-cycle index at which the responder acks; <0 or >=TO means never.
    task automatic do_op(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int ack_wait);
        res_t        r;
        bit          bad, timeout;
        int          nwait;
        logic [31:0] pc;
        bad     = is_bad(size, addr);
        timeout = (ack_wait < 0) || (ack_wait >= TO);
        nwait   = timeout ? TO : ack_wait + 1;
        pc      = $urandom;
        @(negedge clk);
        r.due = cyc + 1 + (bad ? 0 : nwait);
        r.ld  = '0;
        if (bad)          r.flags = we ? 4'b0010 : 4'b0100;
        else if (timeout) r.flags = 4'b1001;
        else begin
            r.flags = 4'b1000;
            if (!we) r.ld = load_value(size, uns, addr, rdata);
        end
        res_q.push_back(r);
        if (!bad) bus_q.push_back(bus_expect(we, size, addr, wdata, pc));
        op_valid    = 1'b1;
        op_we       = we;
        op_size     = size;
        op_unsigned = uns;
        op_addr     = addr;
        op_wdata    = wdata;
        op_pc       = pc;
        m_ack       = 1'($urandom);
        m_rdata     = $urandom;
        #1 check("stall_issue", stall, !bad);
        if (bad) begin
            @(negedge clk);
            op_valid = 1'b0;
            m_ack    = 1'b0;
            check("req_after_misaligned", m_req, 1'b0);
            return;
        end
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            check("req_wait", m_req, 1'b1);
            check("stall_wait", stall, 1'b1);
            m_ack   = (i == ack_wait);
            m_rdata = (i == ack_wait) ? rdata : $urandom;
        end
        @(negedge clk);
        check("req_done", m_req, 1'b0);
        check("stall_done", stall, 1'b0);
        m_ack   = 1'($urandom);
        m_rdata = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
            m_ack    = 1'($urandom);
            m_rdata  = $urandom;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},   stall,    1'b0);
        check({tag, "_done"},    done,     1'b0);
        check({tag, "_err"},     {err_adel, err_ades, err_bus}, 3'b000);
        check({tag, "_ld_data"}, ld_data,  32'h0);
        check({tag, "_m_req"},   m_req,    1'b0);
        check({tag, "_m_we"},    m_we,     1'b0);
        check({tag, "_m_addr"},  m_addr,   32'h0);
        check({tag, "_m_be"},    m_be,     4'h0);
        check({tag, "_m_wdata"}, m_wdata,  32'h0);
        check({tag, "_m_pc"},    m_pc,     32'h0);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        bus_q.push_back(bus_expect(1'b0, SIZE_WORD, 32'h20, 32'h0, 32'h0000_0BAD));
        op_valid    = 1'b1;
        op_we       = 1'b0;
        op_size     = SIZE_WORD;
        op_unsigned = 1'b0;
        op_addr     = 32'h20;
        op_wdata    = 32'h0;
        op_pc       = 32'h0000_0BAD;
        m_ack       = 1'b0;
        @(negedge clk);
        check("rst_wait0_req", m_req, 1'b1);
        @(negedge clk);
        check("rst_wait1_req", m_req, 1'b1);
        reset    = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("wait_reset");
        @(negedge clk);
        check("no_done_after_reset", done, 1'b0);
    endtask

    // ---------------- monitors ----------------
    initial begin : result_monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (done || err_adel || err_ades || err_bus) begin
                if (res_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_result: flags=%b with nothing outstanding (cycle %0d)",
                             {done, err_adel, err_ades, err_bus}, cyc);
                end else begin
                    r = res_q.pop_front();
                    check("result_flags", {done, err_adel, err_ades, err_bus}, r.flags);
                    check("result_cycle", cyc, r.due);
                    if (done) check("ld_data", ld_data, r.ld);
                end
            end
        end
    end

    initial begin : bus_monitor
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (m_req) begin
                if (bus_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_req: m_req=1 with no accepted op, m_addr=0x%08h (cycle %0d)",
                             m_addr, cyc);
                end else begin
                    check("m_we",   m_we,   bus_q[0].we);
                    check("m_addr", m_addr, bus_q[0].addr);
                    check("m_be",   m_be,   bus_q[0].be);
                    check("m_pc",   m_pc,   bus_q[0].pc);
                    if (bus_q[0].we) check("m_wdata", m_wdata, bus_q[0].wdata);
                end
            end else if (prev_req && bus_q.size() != 0) begin
                void'(bus_q.pop_front());
            end
            prev_req = m_req;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        reset       = 1'b1;
        op_valid    = 1'b0;
        op_we       = 1'b0;
        op_size     = 2'b00;
        op_unsigned = 1'b0;
        op_addr     = '0;
        op_wdata    = '0;
        op_pc       = '0;
        m_ack       = 1'b0;
        m_rdata     = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        do_op(1'b1, SIZE_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0,         2);
        do_op(1'b0, SIZE_HALF, 1'b0, 32'h0000_0002, 32'h0,         32'h8001_1234, 0);
        do_op(1'b0, SIZE_HALF, 1'b1, 32'h0000_0002, 32'h0,         32'h8001_1234, 1);
        do_op(1'b0, SIZE_BYTE, 1'b0, 32'h0000_0001, 32'h0,         32'h8001_1234, 0);
        do_op(1'b0, SIZE_BYTE, 1'b0, 32'h0000_0003, 32'h0,         32'h8001_1234, 3);
        do_op(1'b0, SIZE_WORD, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         0);
        do_op(1'b1, SIZE_HALF, 1'b0, 32'h0000_0005, 32'h0000_1234, 32'h0,         0);
        do_op(1'b0, SIZE_RSVD, 1'b0, 32'h0000_0008, 32'h0,         32'h0,         0);
        do_op(1'b1, SIZE_HALF, 1'b0, 32'h0000_0102, 32'h0000_BEEF, 32'h0,         1);
        do_op(1'b0, SIZE_WORD, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, -1);
        do_op(1'b0, SIZE_WORD, 1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, TO - 1);
        idle(1);

        reset_in_wait();
        do_op(1'b1, SIZE_WORD, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0, 0);

        do_op(1'b0, SIZE_WORD, 1'b0, 32'h0000_0000, 32'h0,         32'h7654_3210, 0);
        do_op(1'b1, SIZE_WORD, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         0);

        for (int n = 0; n < 200; n++) begin
            logic [1:0]  sz;
            logic [31:0] addr;
            int          nb, aw;
            sz   = 2'($urandom);
            addr = $urandom;
            nb   = size_bytes(sz);
            if (nb > 0 && $urandom_range(0, 3) != 0) addr = addr & ~(32'(nb) - 32'h1);
            aw = $urandom_range(0, TO);
            if (aw == TO) aw = -1;
            do_op(1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom, aw);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(3);
        check("results_drained", res_q.size(), 0);
        check("bus_drained",     bus_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
